// File: rtl/sat_pkg.sv
// ---------------------------------------------------------------------------
// sat_pkg
// Shared definitions for the saturating accumulator slice.
//   mode_e          : command encodings carried on in_mode
//   sat_max(width)  : largest signed value representable in 'width' bits
//   sat_min(width)  : smallest signed value representable in 'width' bits
// ---------------------------------------------------------------------------
package sat_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_SUB  = 2'b10,
        MODE_READ = 2'b11
    } mode_e;

    // Computed in 64 bits so any realistic operand width fits before the
    // caller narrows the result with a size cast.
    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int width);
        return -sat_max(width) - longint'(1);
    endfunction

endpackage

// File: rtl/sat_accumulator_if.sv
// ---------------------------------------------------------------------------
// sat_accumulator_if
// Command and result handshake bundle for sat_accumulator.
//   in_valid/in_ready     : command handshake (master drives valid)
//   in_chan/in_mode/in_data : command payload
//   out_valid/out_ready   : result handshake (slave drives valid)
//   out_chan/out_result/out_overflow/out_err : result payload
// Modports:
//   master : command producer / result consumer
//   slave  : the accumulator itself
// ---------------------------------------------------------------------------
interface sat_accumulator_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_WIDTH   = 2
);

    logic                         in_valid;
    logic                         in_ready;
    logic [CH_WIDTH-1:0]          in_chan;
    logic [1:0]                   in_mode;
    logic signed [DATA_WIDTH-1:0] in_data;

    logic                         out_valid;
    logic                         out_ready;
    logic [CH_WIDTH-1:0]          out_chan;
    logic signed [DATA_WIDTH-1:0] out_result;
    logic                         out_overflow;
    logic                         out_err;

    modport master (
        output in_valid, in_chan, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_chan, out_result, out_overflow, out_err
    );

    modport slave (
        input  in_valid, in_chan, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_chan, out_result, out_overflow, out_err
    );

endinterface

// File: rtl/sat_addsub.sv
// ---------------------------------------------------------------------------
// sat_addsub
// Combinational signed add/subtract that clamps to the representable range.
//   a, b     : signed operands (a is the running accumulator)
//   sub      : 1 computes a - b, 0 computes a + b
//   result   : wrapped sum/difference, or the clamped limit on overflow
//   overflow : the true result did not fit in DATA_WIDTH bits
// ---------------------------------------------------------------------------
module sat_addsub
    import sat_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic                         sub,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         overflow
);

    localparam logic signed [DATA_WIDTH-1:0] MAX_VAL = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = DATA_WIDTH'(sat_min(DATA_WIDTH));

    logic signed [DATA_WIDTH-1:0] raw;
    logic                         a_neg;
    logic                         b_neg;
    logic                         raw_neg;

    // Overflow is judged from sign bits only. For subtraction the operand
    // signs must differ, which also covers b = MIN without negating it.
    // An overflowing result always lies on a's side of zero, so a's sign
    // picks the limit.
    always_comb begin
        raw     = sub ? (a - b) : (a + b);
        a_neg   = a[DATA_WIDTH-1];
        b_neg   = b[DATA_WIDTH-1];
        raw_neg = raw[DATA_WIDTH-1];
        if (sub) begin
            overflow = (a_neg != b_neg) && (raw_neg != a_neg);
        end else begin
            overflow = (a_neg == b_neg) && (raw_neg != a_neg);
        end
        if (overflow) begin
            result = a_neg ? MIN_VAL : MAX_VAL;
        end else begin
            result = raw;
        end
    end

endmodule

// File: rtl/sat_accumulator.sv
// ---------------------------------------------------------------------------
// sat_accumulator
// Multi-channel saturating accumulator with a one-deep registered result.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   bus (slave)   : command in (chan/mode/data) and result out, both
//                   valid/ready handshakes; result appears one cycle after
//                   the accepting edge
//   clear_sticky  : pulse that clears every sticky overflow flag
//   sticky_ovf    : per-channel flag, set by any saturating operation
//   ovf_count     : saturation event count, holds at all-ones
// Commands to a channel index >= NUM_CHANNELS are accepted but only
// produce an error result.
// ---------------------------------------------------------------------------
module sat_accumulator
    import sat_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_CHANNELS  = 4,
    parameter int CH_WIDTH      = 2,
    parameter int OVF_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    sat_accumulator_if.slave         bus,
    input  logic                     clear_sticky,
    output logic [NUM_CHANNELS-1:0]  sticky_ovf,
    output logic [OVF_CNT_WIDTH-1:0] ovf_count
);

    logic signed [DATA_WIDTH-1:0] acc [NUM_CHANNELS];

    logic                         out_valid_q;
    logic [CH_WIDTH-1:0]          out_chan_q;
    logic signed [DATA_WIDTH-1:0] out_result_q;
    logic                         out_ovf_q;
    logic                         out_err_q;

    mode_e                        mode;
    logic                         accept;
    logic                         chan_ok;
    logic [NUM_CHANNELS-1:0]      chan_sel;
    logic signed [DATA_WIDTH-1:0] cur_acc;
    logic signed [DATA_WIDTH-1:0] as_result;
    logic                         as_overflow;
    logic signed [DATA_WIDTH-1:0] next_val;
    logic                         next_ovf;
    logic                         counted_ovf;
    logic [NUM_CHANNELS-1:0]      sticky_next;

    assign mode         = mode_e'(bus.in_mode);
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid    = out_valid_q;
    assign bus.out_chan     = out_chan_q;
    assign bus.out_result   = out_result_q;
    assign bus.out_overflow = out_ovf_q;
    assign bus.out_err      = out_err_q;

    // Decode the channel index into a one-hot select and mux out the
    // addressed accumulator. An out-of-range index leaves the select all
    // zero, which doubles as the error indication.
    always_comb begin
        chan_sel = '0;
        cur_acc  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (bus.in_chan == CH_WIDTH'(i)) begin
                chan_sel[i] = 1'b1;
                cur_acc     = acc[i];
            end
        end
    end

    assign chan_ok = |chan_sel;

    sat_addsub #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_addsub (
        .a        (cur_acc),
        .b        (bus.in_data),
        .sub      (mode == MODE_SUB),
        .result   (as_result),
        .overflow (as_overflow)
    );

    // Pick the value written back to the accumulator and reported on the
    // result port. READ writes the current value back unchanged.
    always_comb begin
        next_val = cur_acc;
        next_ovf = 1'b0;
        case (mode)
            MODE_LOAD: next_val = bus.in_data;
            MODE_ADD,
            MODE_SUB: begin
                next_val = as_result;
                next_ovf = as_overflow;
            end
            default: next_val = cur_acc;
        endcase
        if (!chan_ok) begin
            next_val = '0;
            next_ovf = 1'b0;
        end
    end

    assign counted_ovf = accept && chan_ok && next_ovf;

    // Sticky update ordered clear-then-set so a saturation in the same
    // cycle as a clear (global or by LOAD) leaves the flag set.
    always_comb begin
        sticky_next = clear_sticky ? '0 : sticky_ovf;
        if (accept && (mode == MODE_LOAD)) begin
            sticky_next = sticky_next & ~chan_sel;
        end
        if (counted_ovf) begin
            sticky_next = sticky_next | chan_sel;
        end
    end

    // All state: accumulators, result register, flags and event counter.
    // The accumulator is written on the accept edge so a back-to-back
    // command to the same channel sees the updated value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                acc[i] <= '0;
            end
            out_valid_q  <= 1'b0;
            out_chan_q   <= '0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
            out_err_q    <= 1'b0;
            sticky_ovf   <= '0;
            ovf_count    <= '0;
        end else begin
            if (accept) begin
                out_valid_q  <= 1'b1;
                out_chan_q   <= bus.in_chan;
                out_result_q <= next_val;
                out_ovf_q    <= next_ovf;
                out_err_q    <= !chan_ok;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (accept && chan_sel[i]) begin
                    acc[i] <= next_val;
                end
            end
            sticky_ovf <= sticky_next;
            if (counted_ovf && (ovf_count != '1)) begin
                ovf_count <= ovf_count + OVF_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/sat_accumulator.md
Name: sat_accumulator

Overview:
- Multi-channel saturating accumulator. Generalises the team's combinational saturating adder to N accumulation channels, with add/subtract/load/read modes.
- Adds a registered valid/ready output stage, per-channel sticky overflow flags and a saturating overflow event counter.
- Sits between sample producers (filters, mixers) and downstream consumers that need bounded signed running sums.

Parameters:
- DATA_WIDTH, 16, signed two's-complement width of operands, accumulators and result.
- NUM_CHANNELS, 4, number of independent accumulators.
- CH_WIDTH, 2, width of channel index; must satisfy 2**CH_WIDTH >= NUM_CHANNELS.
- OVF_CNT_WIDTH, 8, width of the saturating overflow event counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, command valid.
- in_ready, output, 1, command accepted when in_valid & in_ready.
- in_chan, input, CH_WIDTH, target channel.
- in_mode, input, 2, 00 LOAD, 01 ADD, 10 SUB, 11 READ.
- in_data, input, DATA_WIDTH, signed operand; ignored for READ.
- clear_sticky, input, 1, one-cycle pulse that clears all sticky flags.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts when out_valid & out_ready.
- out_chan, output, CH_WIDTH, channel of the result.
- out_result, output, DATA_WIDTH, signed accumulator value after the operation.
- out_overflow, output, 1, this operation saturated.
- out_err, output, 1, in_chan >= NUM_CHANNELS.
- sticky_ovf, output, NUM_CHANNELS, per-channel sticky overflow flags.
- ovf_count, output, OVF_CNT_WIDTH, total saturation events.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All accumulators = 0.
  - out_valid=0, out_chan=0, out_result=0, out_overflow=0, out_err=0.
  - sticky_ovf=0, ovf_count=0.
  - in_ready=1 during the cycle after reset.
  - Reset mid-operation discards any pending output and all state.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept occurs when in_valid & in_ready.
  - Latency 1: the output register loads on the accept edge, so out_valid=1 in the following cycle.
  - out_valid stays high with stable out_* until out_ready.
  - If there is no accept in the cycle out_ready consumes the output, out_valid falls to 0.
  - Full throughput of 1 op/cycle while out_ready=1, including back-to-back ops on the same channel. The accumulator is written on the accept edge, so the next op sees the updated value.
- Arithmetic (acc = accumulator[in_chan], MAX = 2**(DATA_WIDTH-1)-1, MIN = -(MAX+1)):
  - LOAD: acc <= in_data; overflow=0.
  - ADD: sum = acc + in_data in DATA_WIDTH bits.
    - Overflow when the operand signs are equal and the sum sign differs from them.
    - Saturate to MIN if acc is negative, otherwise MAX.
  - SUB: diff = acc - in_data in DATA_WIDTH bits.
    - Overflow when the operand signs differ and the diff sign differs from acc's sign.
    - Saturate to MIN if acc is negative, otherwise MAX.
    - Subtracting MIN is handled by this rule; do not compute -in_data separately.
  - READ: acc unchanged; out_result = acc; overflow=0.
  - The saturated or plain value is written to acc and also to out_result.
- Invalid channel (in_chan >= NUM_CHANNELS):
  - The command is accepted.
  - No accumulator, sticky or counter change.
  - out_result=0, out_overflow=0, out_err=1.
- Sticky flags:
  - sticky_ovf[ch] sets on an overflowing accept to channel ch.
  - LOAD to ch clears sticky_ovf[ch].
  - clear_sticky clears all flags.
  - If a set and a clear hit the same flag in the same cycle, the set wins.
- ovf_count increments by 1 per overflowing accept and holds at all-ones; it is unaffected by clear_sticky.

Decomposition:
- Shared package sat_pkg holds:
  - mode encodings MODE_LOAD, MODE_ADD, MODE_SUB, MODE_READ;
  - functions sat_max(width) and sat_min(width).
- Sub-module sat_addsub: combinational DATA_WIDTH add/sub with saturation and overflow output. Instantiated once on the selected accumulator.

Test Plan:
- LOAD ch0 100, ADD ch0 200 -> out_result=300, out_overflow=0, sticky_ovf[0]=0, latency 1 cycle.
- LOAD ch1 32000, ADD ch1 1000 -> out_result=32767, out_overflow=1, sticky_ovf[1]=1, ovf_count=1; following READ ch1 -> 32767.
- LOAD ch2 0, SUB ch2 -32768 -> 32767 with overflow. LOAD ch2 -32768, SUB ch2 1 -> -32768 with overflow, ovf_count=2.
- Hold out_ready=0 with in_valid=1 for 3 cycles -> in_ready=0 after the first accept, out_* stable, no accumulator change. Release -> ADD stream resumes with no lost or duplicated ops.
- With NUM_CHANNELS=3: command to ch3 -> out_err=1, out_result=0, accumulators unchanged. clear_sticky coinciding with overflow on ch1 -> sticky_ovf[1]=1.
- Assert rst mid-stream while out_valid=1 -> next cycle out_valid=0, all accumulators read back 0, ovf_count=0.
